booth_mul_scheduler: RTL

// Shares one booth_radix_2 multiplier between two requesters (port 0, port 1) with round-robin arbitration.

---
 rtl/booth_mul_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/booth_mul_scheduler.sv
// Round-robin scheduler sharing one radix-2 Booth multiplier between two ports.
// Sequences LOAD/RUN/WAIT per operation and returns the product to the owner.
module booth_mul_scheduler #(
  parameter int WIDTH    = 8,
  parameter int N_CYCLES = WIDTH,
  parameter int TIMEOUT  = 4,
  parameter int CNT_W    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack0,
  output logic               ack1,
  output logic               res_valid0,
  output logic               res_valid1,
  output logic [2*WIDTH-1:0] result0,
  output logic [2*WIDTH-1:0] result1,
  output logic               err,
  output logic               busy,
  output logic               mul_start,
  output logic               mul_enable,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic               mul_done,
  input  logic [2*WIDTH-1:0] mul_product
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_WAIT,
    S_RESP
  } state_t;

  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(N_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               owner_q, owner_d;
  logic               last_q, last_d;
  logic               err_q, err_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic [2*WIDTH-1:0] res0_q, res0_d;
  logic [2*WIDTH-1:0] res1_q, res1_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    err_d   = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    unique case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On contention the port that was not served last wins
          owner_d = (req0 && req1) ? ~last_q : req1;
          last_d  = owner_d;
          mul_a_d = owner_d ? a1 : a0;
          mul_b_d = owner_d ? b1 : b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == RUN_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (mul_done) begin
          if (owner_q) res1_d = mul_product;
          else         res0_d = mul_product;
          state_d = S_RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      err_q   <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      err_q   <= err_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

  assign mul_start  = (state_q == S_LOAD);
  assign mul_enable = (state_q == S_RUN);
  assign ack0       = mul_start && !owner_q;
  assign ack1       = mul_start && owner_q;
  assign res_valid0 = (state_q == S_RESP) && !owner_q;
  assign res_valid1 = (state_q == S_RESP) && owner_q;
  assign busy       = (state_q != S_IDLE);
  assign err        = err_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign result0    = res0_q;
  assign result1    = res1_q;

endmodule
